wb_sequencer: RTL and testbench

Write-back sequencer driving the single write port of the 32 x 32-bit register file: the writer side of the RegWrite/rd/WD3 interface. It merges single-cycle ALU results with back-pressurable memory/multi-cycle results through a small FIFO and issues at most one register write per cycle. It also keeps a pending-write scoreboard so decode can stall on RAW hazards against in-flight destinations. It sits between the execute/memory stages and the register file.

---
 rtl/wb_sequencer.sv | 148 ++++++++++++++
 tb/tb_wb_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sequencer.sv
// Write-back sequencer: merges ALU and FIFO-buffered memory results into the single
// register-file write port and tracks pending destinations. Optional: WB_FIFO_BYPASS_EN.
module wb_sequencer #(
   parameter int FIFO_DEPTH = 4,
   parameter int XLEN       = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            issue_valid,
   input  logic [4:0]      issue_rd,
   input  logic            alu_valid,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_data,
   input  logic            mem_valid,
   output logic            mem_ready,
   input  logic [4:0]      mem_rd,
   input  logic [XLEN-1:0] mem_data,
   input  logic [4:0]      rs1,
   input  logic [4:0]      rs2,
   output logic            hazard,
   output logic            RegWrite,
   output logic [4:0]      rd,
   output logic [XLEN-1:0] WD3
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

   logic [4:0]      fifo_rd   [FIFO_DEPTH];
   logic [XLEN-1:0] fifo_data [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_reg;
   logic [AW-1:0]   rd_ptr_reg;
   logic [AW:0]     count_reg;

   logic full;
   logic empty;
   logic push;
   logic pop;
   logic bypass;
   logic fifo_write;

   logic            sel_valid;
   logic [4:0]      sel_rd;
   logic [XLEN-1:0] sel_data;

   logic [31:0] pending_reg;
   logic [31:0] pending_next;

   assign full      = (count_reg == FULL_COUNT);
   assign empty     = (count_reg == '0);
   assign mem_ready = !full && !rst;
   assign push      = mem_valid && mem_ready;
   // ALU results always win the write port; the FIFO only drains in ALU gaps.
   assign pop       = !alu_valid && !empty;

`ifdef WB_FIFO_BYPASS_EN
   assign bypass = push && empty && !alu_valid;
`else
   assign bypass = 1'b0;
`endif

   assign fifo_write = push && !bypass;

   always_ff @(posedge clk) begin
      if (fifo_write) begin
         fifo_rd[wr_ptr_reg]   <= mem_rd;
         fifo_data[wr_ptr_reg] <= mem_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (fifo_write) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({fifo_write, pop})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_comb begin
      sel_valid = 1'b0;
      sel_rd    = rd;
      sel_data  = WD3;
      if (alu_valid) begin
         sel_valid = 1'b1;
         sel_rd    = alu_rd;
         sel_data  = alu_data;
      end else if (pop) begin
         sel_valid = 1'b1;
         sel_rd    = fifo_rd[rd_ptr_reg];
         sel_data  = fifo_data[rd_ptr_reg];
      end else if (bypass) begin
         sel_valid = 1'b1;
         sel_rd    = mem_rd;
         sel_data  = mem_data;
      end
   end

   // x0 results still occupy the port for a cycle but never assert the write enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         RegWrite <= 1'b0;
         rd       <= '0;
         WD3      <= '0;
      end else begin
         RegWrite <= sel_valid && (sel_rd != 5'd0);
         rd       <= sel_rd;
         WD3      <= sel_data;
      end
   end

   generate
      for (genvar gi = 0; gi < 32; gi++) begin : g_pending
         if (gi == 0) begin : g_zero
            assign pending_next[gi] = 1'b0;
         end else begin : g_bit
            logic set_bit;
            logic clr_bit;
            assign set_bit = issue_valid && (issue_rd == 5'(gi));
            assign clr_bit = RegWrite && (rd == 5'(gi));
            // A re-issue of the register being retired keeps it pending.
            assign pending_next[gi] = set_bit | (pending_reg[gi] & ~clr_bit);
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_reg <= '0;
      end else begin
         pending_reg <= pending_next;
      end
   end

   assign hazard = pending_reg[rs1] | pending_reg[rs2];

endmodule

// File: tb/tb_wb_sequencer.sv
// Bench for wb_sequencer: directed cases plus randomized traffic checked against a
// queue-based reference model of the write-back rules.
module tb_wb_sequencer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        mem_valid;
   logic        mem_ready;
   logic [4:0]  mem_rd;
   logic [31:0] mem_data;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic        hazard;
   logic        RegWrite;
   logic [4:0]  rd;
   logic [31:0] WD3;

   always #5 clk = ~clk;

   wb_sequencer #(.FIFO_DEPTH(DEPTH), .XLEN(32)) dut (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
      .rs1(rs1), .rs2(rs2), .hazard(hazard),
      .RegWrite(RegWrite), .rd(rd), .WD3(WD3)
   );

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   ent_t        model_q[$];
   bit [31:0]   model_pend = '0;
   logic        model_we = 1'b0;
   logic [4:0]  model_rd = '0;
   logic [31:0] model_wd = '0;
   bit          model_accept = 1'b0;

   int tests_run = 0;
   int tests_failed = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock edge of the write-back rules, applied to the inputs present at that edge.
   task automatic model_step();
      ent_t e;
      bit   bypassed;
      bypassed = 1'b0;
      if (rst) begin
         model_q.delete();
         model_pend   = '0;
         model_we     = 1'b0;
         model_rd     = '0;
         model_wd     = '0;
         model_accept = 1'b0;
         return;
      end
      model_accept = mem_valid && (model_q.size() < DEPTH);
      if (model_we) model_pend[model_rd] = 1'b0;
      if (issue_valid && issue_rd != 5'd0) model_pend[issue_rd] = 1'b1;
      if (alu_valid) begin
         model_rd = alu_rd;
         model_wd = alu_data;
         model_we = (alu_rd != 5'd0);
      end else if (model_q.size() > 0) begin
         e = model_q.pop_front();
         model_rd = e.rd;
         model_wd = e.data;
         model_we = (e.rd != 5'd0);
      end
`ifdef WB_FIFO_BYPASS_EN
      else if (model_accept) begin
         model_rd = mem_rd;
         model_wd = mem_data;
         model_we = (mem_rd != 5'd0);
         bypassed = 1'b1;
      end
`endif
      else begin
         model_we = 1'b0;
      end
      if (model_accept && !bypassed) begin
         e.rd = mem_rd;
         e.data = mem_data;
         model_q.push_back(e);
      end
   endtask

   // Inputs are driven just after a rising edge; this checks the combinational outputs,
   // advances the model, and checks the registered outputs after the next edge.
   task automatic tick();
      #1;
      chk("mem_ready", 32'(mem_ready), rst ? 32'd0 : 32'(model_q.size() < DEPTH));
      chk("hazard", 32'(hazard), 32'(model_pend[rs1] | model_pend[rs2]));
      model_step();
      @(posedge clk);
      #1;
      chk("RegWrite", 32'(RegWrite), 32'(model_we));
      chk("rd", 32'(rd), 32'(model_rd));
      chk("WD3", WD3, model_wd);
   endtask

   task automatic set_idle();
      issue_valid = 1'b0; issue_rd = '0;
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
      rs1 = '0; rs2 = '0;
   endtask

   initial begin
      set_idle();
      rst = 1'b1;

      // Reset with an offered memory result
      mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h99; rs1 = 5'd5;
      tick();
      tick();
      chk("rst_we", 32'(RegWrite), 32'd0);
      chk("rst_rd", 32'(rd), 32'd0);
      chk("rst_wd", WD3, 32'd0);
      chk("rst_ready", 32'(mem_ready), 32'd0);
      chk("rst_hazard", 32'(hazard), 32'd0);
      rst = 1'b0;
      mem_valid = 1'b0;
      #1 chk("ready_after_rst", 32'(mem_ready), 32'd1);

      // ALU write
      alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hDEADBEEF;
      tick();
      chk("alu_we", 32'(RegWrite), 32'd1);
      chk("alu_rd", 32'(rd), 32'd10);
      chk("alu_wd", WD3, 32'hDEADBEEF);
      alu_valid = 1'b0;
      tick();
      chk("alu_we_off", 32'(RegWrite), 32'd0);

      // ALU and memory in the same cycle
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h55;
      mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h11;
      tick();
      chk("con_alu_rd", 32'(rd), 32'd1);
      alu_valid = 1'b0; mem_valid = 1'b0;
      tick();
      chk("con_mem_we", 32'(RegWrite), 32'd1);
      chk("con_mem_rd", 32'(rd), 32'd3);
      chk("con_mem_wd", WD3, 32'h11);

      // Fill the FIFO under continuous ALU traffic, then drain
      alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h22;
      for (int i = 0; i < DEPTH; i++) begin
         mem_valid = 1'b1; mem_rd = 5'(20 + i); mem_data = 32'hA0 + 32'(i);
         tick();
      end
      mem_valid = 1'b0;
      #1 chk("full_ready", 32'(mem_ready), 32'd0);
      alu_valid = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         tick();
         chk("drain_rd", 32'(rd), 32'(20 + i));
         chk("drain_wd", WD3, 32'hA0 + 32'(i));
         if (i == 0) chk("ready_after_pop", 32'(mem_ready), 32'd1);
      end

      // Scoreboard
      issue_valid = 1'b1; issue_rd = 5'd7;
      tick();
      issue_valid = 1'b0;
      rs1 = 5'd7; rs2 = 5'd0;
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
      #1 chk("sb_pending", 32'(hazard), 32'd1);
      tick();
      alu_valid = 1'b0;
      issue_valid = 1'b1; issue_rd = 5'd7;
      #1 chk("sb_write_cycle", 32'(hazard), 32'd1);
      tick();
      issue_valid = 1'b0;
      #1 chk("sb_set_wins", 32'(hazard), 32'd1);
      alu_valid = 1'b1;
      tick();
      alu_valid = 1'b0;
      #1 chk("sb_no_writethrough", 32'(hazard), 32'd1);
      tick();
      #1 chk("sb_cleared", 32'(hazard), 32'd0);
      rs1 = 5'd0; rs2 = 5'd0;
      issue_valid = 1'b1; issue_rd = 5'd0;
      tick();
      issue_valid = 1'b0;
      #1 chk("sb_x0", 32'(hazard), 32'd0);
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
      tick();
      alu_valid = 1'b0;
      chk("x0_we", 32'(RegWrite), 32'd0);

      // Memory latency with an empty FIFO
      mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h44;
      tick();
      mem_valid = 1'b0;
`ifdef WB_FIFO_BYPASS_EN
      chk("byp_we", 32'(RegWrite), 32'd1);
      chk("byp_rd", 32'(rd), 32'd4);
`else
      chk("nobyp_we_n1", 32'(RegWrite), 32'd0);
      tick();
      chk("nobyp_we_n2", 32'(RegWrite), 32'd1);
      chk("nobyp_rd_n2", 32'(rd), 32'd4);
`endif
      tick();

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 199) == 0);
         alu_valid = ($urandom_range(0, 9) < 3);
         alu_rd = 5'($urandom);
         alu_data = $urandom;
         if (!mem_valid && $urandom_range(0, 1) == 1) begin
            mem_valid = 1'b1;
            mem_rd = 5'($urandom);
            mem_data = $urandom;
         end
         issue_valid = ($urandom_range(0, 3) == 0);
         issue_rd = 5'($urandom_range(0, 7));
         rs1 = 5'($urandom_range(0, 7));
         rs2 = 5'($urandom_range(0, 7));
         tick();
         if (model_accept) mem_valid = 1'b0;
      end
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
